uart_rx_fifo_ext: RTL
=====================

# uart_rx_fifo_ext

Parametrised successor to the team's fixed 8N1 UART receiver. Adds:
- configurable frame format: data bits, parity mode, stop bits;
- 3-sample majority voting;
- framing, parity, overrun and break detection;
- buffered valid/ready output through an internal FIFO.

It sits between the external RX pin and the command/configuration logic of the GPS signal generator, clocked from the 16.368 MHz system clock.

## Interface
- `CLKS_PER_BIT`, 142 — system clocks per bit; minimum 8.
- `DATA_BITS`, 8 — data bits per frame, 5..9.
- `PARITY`, 0 — 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1 — 1 or 2.
- `FIFO_DEPTH`, 4 — entries; power of two, ≥2.
- `clk_in` in 1 — system clock.
- `rst_in` in 1 — reset. One clock; reset is synchronous and active-high.
- `rx_in` in 1 — asynchronous serial line, idle high.
- `rx_data_out` out `DATA_BITS` — head-of-FIFO data.
- `rx_valid_out` out 1 — FIFO not empty.
- `rx_ready_in` in 1 — consumer accepts the head word when `rx_valid_out` is also high.
- `parity_err_out` out 1 — parity error flag of the head word; 0 when `PARITY=0`.
- `frame_err_out` out 1 — stop-bit error flag of the head word.
- `overrun_out` out 1 — one-cycle pulse: a completed frame was dropped because the FIFO was full.
- `break_out` out 1 — one-cycle pulse: a break was detected.
- `fifo_count_out` out `$clog2(FIFO_DEPTH+1)` — current occupancy.

## Operation
**Synchronizer:** 2-flop synchronizer on `rx_in`; both flops reset to 1.

**States:** `WAIT_IDLE`, `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
- `WAIT_IDLE`: entered on reset and after a break. Moves to `IDLE` once the synchronized line is high.
- `IDLE`: a synchronized 1→0 transition moves to `START` and clears the bit counter.

**Bit timing:**
- The bit counter runs 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary.
- `HALF = CLKS_PER_BIT/2`.
- Samples are taken at counts `HALF`-1, `HALF` and `HALF`+1. The bit value is the majority of the three, decided at count `HALF`+1.

**Per-state behaviour:**
- `START`: voted 1 → glitch; return to `IDLE` with no output.
- `DATA`: `DATA_BITS` bits, LSB first, shifted into a register.
- `PARITY`: present only if `PARITY≠0`. Error if the received bit differs from the even/odd parity of the data.
- `STOP`:
  - Every stop bit is checked. Any voted 0 sets `frame_err`.
  - The state finishes at the mid-point decision of the last stop bit and goes straight to `IDLE`, without waiting out the second half of the bit. This allows early resynchronisation.

**Break:** all data bits 0, parity bit 0 (if present) and first stop bit 0.
- Pulse `break_out`.
- Do not push to the FIFO.
- Go to `WAIT_IDLE`.

**Push:**
- Every other completed frame, including frames with errors, pushes `{frame_err, parity_err, data}` into the FIFO.
- If the FIFO is full and no pop occurs that cycle, the frame is dropped and `overrun_out` pulses.

## Timing
- **Reset values:**
  - `rx_valid_out`=0, `rx_data_out`=0, all error flags and pulses 0, `fifo_count_out`=0.
  - FSM in `WAIT_IDLE`; counters 0.
- Reset mid-frame discards the partial frame and all FIFO contents.
- A line held low through reset release is never taken as a start bit.
- Start edge to push: cycle of the last stop-bit decision, +1.
- Push into an empty FIFO: `rx_valid_out` high on the next cycle.
- FIFO is show-ahead. Pop on `rx_valid_out && rx_ready_in`; the next word, or `valid`=0, appears on the following cycle.
- Simultaneous push and pop:
  - when full, both are accepted and count is unchanged;
  - when empty, only the push takes effect.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Full/empty are derived from the count.
- `overrun_out` and `break_out` are registered, exactly one cycle wide, and assert in the push-decision cycle +1.
- Data and flags stay stable while `rx_valid_out`=1 and `rx_ready_in`=0.

## Structure
- **Package `uart_pkg`:**
  - parity encodings `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - state enum;
  - `HALF` computation helper.
- **Sub-module `uart_sync_fifo`:** generic synchronous FIFO with parameters `WIDTH` and `DEPTH`, a count output, and push/pop/full/empty signals. It is instantiated with `WIDTH = DATA_BITS+2`.
- The receiver FSM, voter and parity logic stay in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT=16` unless noted.
1. **8N1 baseline:** 8N1, send 0xA5, `rx_ready_in`=1. Expect `rx_data_out`=0xA5, no flags, `rx_valid_out` high for exactly 1 cycle.
2. **Parity:** 7E2, send 0x35 with correct parity, then 0x35 with the parity bit flipped. Expect word 1 flags 00; word 2 `parity_err_out`=1, data 0x35.
3. **Framing:** stop bit driven 0 on 0x3C. Expect 0x3C pushed with `frame_err_out`=1. Expect no break pulse, because the data is non-zero.
4. **Overrun:** `FIFO_DEPTH`=4, `rx_ready_in`=0, send 0x01..0x05. Expect `fifo_count_out`=4 and one `overrun_out` pulse. Then assert ready: pops return 0x01..0x04 in order.
5. **Break and glitch:**
   - Line low for 12 bit times: one `break_out` pulse, FIFO empty, no further start until the line returns high.
   - A 3-cycle low glitch while idle: no output.
6. **Reset mid-frame:** assert `rst_in` during the data bits of 0x77, release while the line is low, then send 0x12. Expect only 0x12 received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
// Holds the parity mode encodings, the receiver state type and the helper
// that computes the mid-bit count used for sampling.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic int half_of(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic show-ahead synchronous FIFO.
// Ports:
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_push/i_data - write request and word
//   i_pop         - read request; head advances on the next cycle
//   o_data        - head word (zero while empty)
//   o_full/o_empty/o_count - occupancy status
// A push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_data,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH+1)-1:0]    o_count
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CNW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNW-1:0]   r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == CNW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || i_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Memory is not reset, so the head is masked while empty.
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_rx_fifo_ext.sv
// Parametrised UART receiver with 3-sample majority voting, parity/framing/
// overrun/break detection and a buffered valid/ready output.
// Ports:
//   clk_in, rst_in      - system clock, synchronous active-high reset
//   rx_in               - asynchronous serial line, idle high
//   rx_data_out/rx_valid_out/rx_ready_in - head-of-FIFO word handshake
//   parity_err_out, frame_err_out        - error flags of the head word
//   overrun_out, break_out               - one-cycle event pulses
//   fifo_count_out      - FIFO occupancy
module uart_rx_fifo_ext
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 142,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             rx_in,
    output logic [DATA_BITS-1:0]             rx_data_out,
    output logic                             rx_valid_out,
    input  logic                             rx_ready_in,
    output logic                             parity_err_out,
    output logic                             frame_err_out,
    output logic                             overrun_out,
    output logic                             break_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_out
);
    localparam int HALF = half_of(CLKS_PER_BIT);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_BITS);
    localparam int WW   = DATA_BITS + 2;
    localparam bit HAS_PARITY = (PARITY != PAR_NONE);

    localparam logic [CW-1:0] C_S0  = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1  = CW'(HALF);
    localparam logic [CW-1:0] C_DEC = CW'(HALF + 1);
    localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] I_LAST_STOP = IW'(STOP_BITS - 1);

    rx_state_t r_state;
    rx_state_t w_next;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rx_prev;
    logic [1:0]           r_settle;
    logic [CW-1:0]        r_bit_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_push;
    logic [WW-1:0]        r_push_word;
    logic                 r_break;
    logic                 r_overrun;

    logic                 w_rx;
    logic                 w_settled;
    logic                 w_at_s0;
    logic                 w_at_s1;
    logic                 w_at_dec;
    logic                 w_at_end;
    logic                 w_vote;
    logic                 w_par_exp;
    logic                 w_break_hit;
    logic                 w_frame_done;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [WW-1:0]        w_head;
    logic [$clog2(FIFO_DEPTH+1)-1:0] w_count;

    assign w_rx      = r_sync2;
    // Synchronizer flops reset high, so the real line level is only known
    // a couple of cycles after reset; a line held low must not look idle.
    assign w_settled = (r_settle == 2'd3);
    assign w_at_s0   = (r_bit_cnt == C_S0);
    assign w_at_s1   = (r_bit_cnt == C_S1);
    assign w_at_dec  = (r_bit_cnt == C_DEC);
    assign w_at_end  = (r_bit_cnt == C_END);
    assign w_vote    = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_par_exp = (PARITY == PAR_EVEN) ? ^r_shift : ~^r_shift;

    assign w_break_hit  = (r_state == ST_STOP) && w_at_dec && (r_bit_idx == '0) &&
                          !w_vote && (r_shift == '0) && (!HAS_PARITY || !r_par_bit);
    assign w_frame_done = (r_state == ST_STOP) && w_at_dec &&
                          (r_bit_idx == I_LAST_STOP) && !w_break_hit;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT_IDLE: if (w_settled && w_rx) w_next = ST_IDLE;
            ST_IDLE:      if (r_rx_prev && !w_rx) w_next = ST_START;
            ST_START: begin
                if (w_at_dec && w_vote) w_next = ST_IDLE;
                else if (w_at_end)      w_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_at_end && (r_bit_idx == I_LAST_DATA)) begin
                    w_next = HAS_PARITY ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY:    if (w_at_end) w_next = ST_STOP;
            ST_STOP: begin
                if (w_break_hit)       w_next = ST_WAIT_IDLE;
                else if (w_frame_done) w_next = ST_IDLE;
            end
            default:      w_next = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_settle    <= '0;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_s0        <= 1'b0;
            r_s1        <= 1'b0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= '0;
            r_break     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1   <= rx_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= w_rx;
            if (!w_settled) begin
                r_settle <= r_settle + 2'd1;
            end

            case (r_state)
                ST_START, ST_DATA, ST_PARITY, ST_STOP:
                    r_bit_cnt <= w_at_end ? '0 : r_bit_cnt + 1'b1;
                default:
                    r_bit_cnt <= '0;
            endcase

            if (w_next != r_state) begin
                r_bit_idx <= '0;
            end else if (w_at_end && (r_state == ST_DATA || r_state == ST_STOP)) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            if (w_at_s0) r_s0 <= w_rx;
            if (w_at_s1) r_s1 <= w_rx;

            if (r_state == ST_IDLE) begin
                r_par_bit <= 1'b0;
                r_perr    <= 1'b0;
                r_ferr    <= 1'b0;
            end else if (w_at_dec) begin
                case (r_state)
                    ST_DATA:   r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    ST_PARITY: begin
                        r_par_bit <= w_vote;
                        r_perr    <= (w_vote != w_par_exp);
                    end
                    ST_STOP:   if (!w_vote) r_ferr <= 1'b1;
                    default:   ;
                endcase
            end

            r_push  <= w_frame_done;
            r_break <= w_break_hit;
            if (w_frame_done) begin
                // The last stop bit's vote is folded in here, it has not reached r_ferr yet.
                r_push_word <= {r_ferr | ~w_vote, r_perr, r_shift};
            end
            r_overrun <= r_push && w_full && !w_pop;
        end
    end

    assign w_pop = !w_empty && rx_ready_in;

    uart_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (r_push),
        .i_data  (r_push_word),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign rx_data_out    = w_head[DATA_BITS-1:0];
    assign rx_valid_out   = !w_empty;
    assign parity_err_out = HAS_PARITY ? w_head[DATA_BITS] : 1'b0;
    assign frame_err_out  = w_head[DATA_BITS+1];
    assign overrun_out    = r_overrun;
    assign break_out      = r_break;
    assign fifo_count_out = w_count;

endmodule
